idu_stage: RTL and testbench

Registered instruction-decode pipeline stage between the fetch unit and the execute unit. It decodes RV32I, or RV64I when DATA_LEN=64, including the W-ops and the ld/lwu/sd instructions. It takes instructions in and passes decoded results out over valid/ready handshakes, flags illegal encodings, and supports a flush. An ebreak halts the stage until reset.

---
 rtl/idu_stage.sv | 436 ++++++++++++++++++++++++++++++++++++++++
 tb/tb_idu_stage.sv | 388 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/idu_stage.sv
// idu_stage: registered RV32I/RV64I instruction-decode stage.
// Valid/ready handshakes on both sides; an accepted ebreak halts intake until reset.
module idu_stage #(
    parameter int unsigned DATA_LEN = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid_i,
    output logic                in_ready_o,
    input  logic [31:0]         inst_i,
    input  logic [DATA_LEN-1:0] pc_i,
    input  logic [DATA_LEN-1:0] src1_i,
    input  logic [DATA_LEN-1:0] src2_i,
    input  logic                flush_i,
    output logic                out_valid_o,
    input  logic                out_ready_i,
    output logic [DATA_LEN-1:0] out_pc_o,
    output logic [4:0]          rs1_o,
    output logic [4:0]          rs2_o,
    output logic [4:0]          rd_o,
    output logic [DATA_LEN-1:0] operand1_o,
    output logic [DATA_LEN-1:0] operand2_o,
    output logic [DATA_LEN-1:0] operand3_o,
    output logic [DATA_LEN-1:0] operand4_o,
    output logic [19:0]         control_sign_o,
    output logic [4:0]          store_sign_o,
    output logic                inst_jump_flag_o,
    output logic                jump_without_o,
    output logic                op_o,
    output logic                dest_wen_o,
    output logic                ebreak_o,
    output logic                illegal_o
);

    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpAuipc  = 7'b0010111;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpImm    = 7'b0010011;
    localparam logic [6:0] OpReg    = 7'b0110011;
    localparam logic [6:0] OpImm32  = 7'b0011011;
    localparam logic [6:0] OpReg32  = 7'b0111011;
    localparam logic [6:0] OpSystem = 7'b1110011;

    localparam logic [31:0] EbreakInst = 32'h0010_0073;
    localparam logic        IsRv64     = (DATA_LEN == 64);

    localparam logic [0:0] StRun  = 1'b0;
    localparam logic [0:0] StHalt = 1'b1;

    // Bit positions inside control_sign
    localparam int unsigned CsDword  = 19;
    localparam int unsigned CsW      = 18;
    localparam int unsigned CsWord   = 17;
    localparam int unsigned CsHalf   = 16;
    localparam int unsigned CsByte   = 15;
    localparam int unsigned CsLoad   = 14;
    localparam int unsigned CsBgeu   = 13;
    localparam int unsigned CsBge    = 12;
    localparam int unsigned CsBne    = 11;
    localparam int unsigned CsBeq    = 10;
    localparam int unsigned CsBltu   = 9;
    localparam int unsigned CsBlt    = 8;
    localparam int unsigned CsCmp    = 7;
    localparam int unsigned CsUnsign = 6;
    localparam int unsigned CsShift  = 5;
    localparam int unsigned CsAl     = 4;
    localparam int unsigned CsLr     = 3;
    localparam int unsigned CsAnd    = 2;
    localparam int unsigned CsXor    = 1;
    localparam int unsigned CsOr     = 0;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       f7_zero;
    logic       f7_alt;
    logic       sh_ok;
    logic       sra_ok;

    assign opcode  = inst_i[6:0];
    assign funct3  = inst_i[14:12];
    assign funct7  = inst_i[31:25];
    assign f7_zero = (funct7 == 7'b0000000);
    assign f7_alt  = (funct7 == 7'b0100000);

    // Upper immediate bits above the shamt field; the shamt is one bit wider on RV64
    assign sh_ok  = IsRv64 ? (inst_i[31:26] == 6'b000000) : (inst_i[31:25] == 7'b0000000);
    assign sra_ok = IsRv64 ? (inst_i[31:26] == 6'b010000) : (inst_i[31:25] == 7'b0100000);

    logic [DATA_LEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    assign imm_i = DATA_LEN'($signed(inst_i[31:20]));
    assign imm_s = DATA_LEN'($signed({inst_i[31:25], inst_i[11:7]}));
    assign imm_b = DATA_LEN'($signed({inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0}));
    assign imm_u = DATA_LEN'($signed({inst_i[31:12], 12'b0}));
    assign imm_j = DATA_LEN'($signed({inst_i[31], inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0}));

    logic is_lui, is_auipc, is_jal, is_jalr, is_branch, is_store, is_reg, is_reg32, is_ebreak;

    assign is_lui    = (opcode == OpLui);
    assign is_auipc  = (opcode == OpAuipc);
    assign is_jal    = (opcode == OpJal);
    assign is_jalr   = (opcode == OpJalr);
    assign is_branch = (opcode == OpBranch);
    assign is_store  = (opcode == OpStore);
    assign is_reg    = (opcode == OpReg);
    assign is_reg32  = (opcode == OpReg32);
    assign is_ebreak = (inst_i == EbreakInst);

    logic                dec_legal;
    logic [19:0]         dec_cs;
    logic [4:0]          dec_ss;
    logic                dec_jf;
    logic                dec_jw;
    logic                dec_op;
    logic [DATA_LEN-1:0] dec_imm;

    // Raw decode: legality, immediate selection and per-instruction control bits
    always_comb begin
        dec_legal = 1'b0;
        dec_cs    = '0;
        dec_ss    = '0;
        dec_jf    = 1'b0;
        dec_jw    = 1'b0;
        dec_op    = 1'b0;
        dec_imm   = '0;
        case (opcode)
            OpLui, OpAuipc: begin
                dec_legal = 1'b1;
                dec_imm   = imm_u;
            end
            OpJal: begin
                dec_legal = 1'b1;
                dec_imm   = imm_j;
                dec_jw    = 1'b1;
            end
            OpJalr: begin
                dec_legal = (funct3 == 3'b000);
                dec_imm   = imm_i;
                dec_jw    = 1'b1;
            end
            OpBranch: begin
                dec_legal = 1'b1;
                dec_imm   = imm_b;
                dec_jf    = 1'b1;
                dec_op    = 1'b1;
                case (funct3)
                    3'b000:  dec_cs[CsBeq]  = 1'b1;
                    3'b001:  dec_cs[CsBne]  = 1'b1;
                    3'b100:  dec_cs[CsBlt]  = 1'b1;
                    3'b101:  dec_cs[CsBge]  = 1'b1;
                    3'b110:  dec_cs[CsBltu] = 1'b1;
                    3'b111:  dec_cs[CsBgeu] = 1'b1;
                    default: dec_legal      = 1'b0;
                endcase
            end
            OpLoad: begin
                dec_legal       = 1'b1;
                dec_imm         = imm_i;
                dec_cs[CsLoad]  = 1'b1;
                case (funct3)
                    3'b000: dec_cs[CsByte] = 1'b1;
                    3'b001: dec_cs[CsHalf] = 1'b1;
                    3'b010: dec_cs[CsWord] = 1'b1;
                    3'b011: begin
                        dec_cs[CsDword] = 1'b1;
                        dec_legal       = IsRv64;
                    end
                    3'b100: begin
                        dec_cs[CsByte]   = 1'b1;
                        dec_cs[CsUnsign] = 1'b1;
                    end
                    3'b101: begin
                        dec_cs[CsHalf]   = 1'b1;
                        dec_cs[CsUnsign] = 1'b1;
                    end
                    3'b110: begin
                        dec_cs[CsWord]   = 1'b1;
                        dec_cs[CsUnsign] = 1'b1;
                        dec_legal        = IsRv64;
                    end
                    default: dec_legal = 1'b0;
                endcase
            end
            OpStore: begin
                dec_legal = 1'b1;
                dec_imm   = imm_s;
                dec_ss[0] = 1'b1;
                case (funct3)
                    3'b000: dec_ss[1] = 1'b1;
                    3'b001: dec_ss[2] = 1'b1;
                    3'b010: dec_ss[3] = 1'b1;
                    3'b011: begin
                        dec_ss[4] = 1'b1;
                        dec_legal = IsRv64;
                    end
                    default: dec_legal = 1'b0;
                endcase
            end
            OpImm: begin
                dec_legal = 1'b1;
                dec_imm   = imm_i;
                case (funct3)
                    3'b010: begin
                        dec_cs[CsCmp] = 1'b1;
                        dec_op        = 1'b1;
                    end
                    3'b011: begin
                        dec_cs[CsCmp]    = 1'b1;
                        dec_cs[CsUnsign] = 1'b1;
                        dec_op           = 1'b1;
                    end
                    3'b100: dec_cs[CsXor] = 1'b1;
                    3'b110: dec_cs[CsOr]  = 1'b1;
                    3'b111: dec_cs[CsAnd] = 1'b1;
                    3'b001: begin
                        dec_cs[CsShift] = 1'b1;
                        dec_cs[CsLr]    = 1'b1;
                        dec_legal       = sh_ok;
                    end
                    3'b101: begin
                        dec_cs[CsShift] = 1'b1;
                        dec_legal       = sh_ok | sra_ok;
                    end
                    default: ;
                endcase
            end
            OpReg: begin
                dec_legal = f7_zero;
                case (funct3)
                    3'b000: begin
                        dec_legal = f7_zero | f7_alt;
                        dec_op    = f7_alt;
                    end
                    3'b001: begin
                        dec_cs[CsShift] = 1'b1;
                        dec_cs[CsLr]    = 1'b1;
                    end
                    3'b010: begin
                        dec_cs[CsCmp] = 1'b1;
                        dec_op        = 1'b1;
                    end
                    3'b011: begin
                        dec_cs[CsCmp]    = 1'b1;
                        dec_cs[CsUnsign] = 1'b1;
                        dec_op           = 1'b1;
                    end
                    3'b100: dec_cs[CsXor] = 1'b1;
                    3'b101: begin
                        dec_cs[CsShift] = 1'b1;
                        dec_legal       = f7_zero | f7_alt;
                    end
                    3'b110: dec_cs[CsOr]  = 1'b1;
                    default: dec_cs[CsAnd] = 1'b1;
                endcase
            end
            OpImm32: begin
                dec_imm    = imm_i;
                dec_cs[CsW] = 1'b1;
                case (funct3)
                    3'b000: dec_legal = IsRv64;
                    3'b001: begin
                        dec_cs[CsShift] = 1'b1;
                        dec_cs[CsLr]    = 1'b1;
                        dec_legal       = IsRv64 & f7_zero;
                    end
                    3'b101: begin
                        dec_cs[CsShift] = 1'b1;
                        dec_legal       = IsRv64 & (f7_zero | f7_alt);
                    end
                    default: dec_legal = 1'b0;
                endcase
            end
            OpReg32: begin
                dec_cs[CsW] = 1'b1;
                case (funct3)
                    3'b000: begin
                        dec_legal = IsRv64 & (f7_zero | f7_alt);
                        dec_op    = f7_alt;
                    end
                    3'b001: begin
                        dec_cs[CsShift] = 1'b1;
                        dec_cs[CsLr]    = 1'b1;
                        dec_legal       = IsRv64 & f7_zero;
                    end
                    3'b101: begin
                        dec_cs[CsShift] = 1'b1;
                        dec_legal       = IsRv64 & (f7_zero | f7_alt);
                    end
                    default: dec_legal = 1'b0;
                endcase
            end
            OpSystem: begin
                dec_legal = is_ebreak;
                dec_imm   = imm_i;
            end
            default: dec_legal = 1'b0;
        endcase
        if (dec_legal) begin
            dec_cs[CsAl] = inst_i[30];
        end
    end

    logic [DATA_LEN-1:0] op1_d, op2_d, op3_d, op4_d;
    logic [19:0]         cs_d;
    logic [4:0]          ss_d;
    logic                jf_d, jw_d, op_d, wen_d;

    // Next bundle: operand muxing plus gating of all control when the encoding is illegal
    always_comb begin
        if (is_auipc) begin
            op1_d = pc_i;
        end else if (is_jal | is_jalr | is_lui) begin
            op1_d = '0;
        end else begin
            op1_d = src1_i;
        end
        if (is_jal | is_jalr) begin
            op2_d = pc_i + DATA_LEN'(4);
        end else if (is_branch | is_reg | is_reg32) begin
            op2_d = src2_i;
        end else begin
            op2_d = dec_imm;
        end
        op3_d = is_jalr ? src1_i : pc_i;
        op4_d = dec_imm;
        cs_d  = dec_legal ? dec_cs : '0;
        ss_d  = dec_legal ? dec_ss : '0;
        jf_d  = dec_legal & dec_jf;
        jw_d  = dec_legal & dec_jw;
        op_d  = dec_legal & dec_op;
        wen_d = dec_legal & ~(is_branch | is_store | is_ebreak);
    end

    logic [0:0] state_q, state_d;
    logic       out_valid_q, out_valid_d;
    logic       accept;

    assign in_ready_o = (state_q == StRun) & ~flush_i & (~out_valid_q | out_ready_i);
    assign accept     = in_valid_i & in_ready_o;

    // Handshake and halt next-state; flush wins over a drain and blocks intake
    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        if (flush_i) begin
            out_valid_d = 1'b0;
        end else if (accept) begin
            out_valid_d = 1'b1;
        end else if (out_ready_i) begin
            out_valid_d = 1'b0;
        end
        if (accept && is_ebreak) begin
            state_d = StHalt;
        end
    end

    // Control state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StRun;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
        end
    end

    logic [DATA_LEN-1:0] pc_q, op1_q, op2_q, op3_q, op4_q;
    logic [4:0]          rs1_q, rs2_q, rd_q;
    logic [19:0]         cs_q;
    logic [4:0]          ss_q;
    logic                jf_q, jw_q, op_q, wen_q, ebreak_q, illegal_q;

    // Decoded bundle loads only on accept and holds otherwise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q      <= '0;
            op1_q     <= '0;
            op2_q     <= '0;
            op3_q     <= '0;
            op4_q     <= '0;
            rs1_q     <= '0;
            rs2_q     <= '0;
            rd_q      <= '0;
            cs_q      <= '0;
            ss_q      <= '0;
            jf_q      <= 1'b0;
            jw_q      <= 1'b0;
            op_q      <= 1'b0;
            wen_q     <= 1'b0;
            ebreak_q  <= 1'b0;
            illegal_q <= 1'b0;
        end else if (accept) begin
            pc_q      <= pc_i;
            op1_q     <= op1_d;
            op2_q     <= op2_d;
            op3_q     <= op3_d;
            op4_q     <= op4_d;
            rs1_q     <= inst_i[19:15];
            rs2_q     <= inst_i[24:20];
            rd_q      <= inst_i[11:7];
            cs_q      <= cs_d;
            ss_q      <= ss_d;
            jf_q      <= jf_d;
            jw_q      <= jw_d;
            op_q      <= op_d;
            wen_q     <= wen_d;
            ebreak_q  <= is_ebreak;
            illegal_q <= ~dec_legal;
        end
    end

    assign out_valid_o      = out_valid_q;
    assign out_pc_o         = pc_q;
    assign operand1_o       = op1_q;
    assign operand2_o       = op2_q;
    assign operand3_o       = op3_q;
    assign operand4_o       = op4_q;
    assign rs1_o            = rs1_q;
    assign rs2_o            = rs2_q;
    assign rd_o             = rd_q;
    assign control_sign_o   = cs_q;
    assign store_sign_o     = ss_q;
    assign inst_jump_flag_o = jf_q;
    assign jump_without_o   = jw_q;
    assign op_o             = op_q;
    assign dest_wen_o       = wen_q;
    assign ebreak_o         = ebreak_q;
    assign illegal_o        = illegal_q;

endmodule

// File: tb/tb_idu_stage.sv
// tb_idu_stage: drives an RV32 and an RV64 instance in lockstep and checks both against
// a mnemonic-table decode model plus a transaction-level handshake model.
module tb_idu_stage;

    localparam logic [31:0] Ebreak = 32'h0010_0073;

    typedef struct packed {
        logic [63:0] pc, o1, o2, o3, o4;
        logic [4:0]  rs1, rs2, rd;
        logic [19:0] cs;
        logic [4:0]  ss;
        logic        jf, jw, op, wen, ebk, ill;
    } bundle_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0, flush = 1'b0, out_ready = 1'b0;
    logic [31:0] inst = '0;
    logic [63:0] pc = '0, src1 = '0, src2 = '0;

    always #5 clk = ~clk;

    logic        rdy32, vld32, jf32, jw32, op32, wen32, ebk32, ill32;
    logic [31:0] pc32, a32, b32, c32, d32;
    logic [4:0]  rs1_32, rs2_32, rd32, ss32;
    logic [19:0] cs32;
    logic        rdy64, vld64, jf64, jw64, op64, wen64, ebk64, ill64;
    logic [63:0] pc64, a64, b64, c64, d64;
    logic [4:0]  rs1_64, rs2_64, rd64, ss64;
    logic [19:0] cs64;

    idu_stage #(.DATA_LEN(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid_i(in_valid), .in_ready_o(rdy32), .inst_i(inst),
        .pc_i(pc[31:0]), .src1_i(src1[31:0]), .src2_i(src2[31:0]), .flush_i(flush),
        .out_valid_o(vld32), .out_ready_i(out_ready), .out_pc_o(pc32), .rs1_o(rs1_32),
        .rs2_o(rs2_32), .rd_o(rd32), .operand1_o(a32), .operand2_o(b32), .operand3_o(c32),
        .operand4_o(d32), .control_sign_o(cs32), .store_sign_o(ss32), .inst_jump_flag_o(jf32),
        .jump_without_o(jw32), .op_o(op32), .dest_wen_o(wen32), .ebreak_o(ebk32),
        .illegal_o(ill32)
    );

    idu_stage #(.DATA_LEN(64)) dut64 (
        .clk(clk), .rst_n(rst_n), .in_valid_i(in_valid), .in_ready_o(rdy64), .inst_i(inst),
        .pc_i(pc), .src1_i(src1), .src2_i(src2), .flush_i(flush),
        .out_valid_o(vld64), .out_ready_i(out_ready), .out_pc_o(pc64), .rs1_o(rs1_64),
        .rs2_o(rs2_64), .rd_o(rd64), .operand1_o(a64), .operand2_o(b64), .operand3_o(c64),
        .operand4_o(d64), .control_sign_o(cs64), .store_sign_o(ss64), .inst_jump_flag_o(jf64),
        .jump_without_o(jw64), .op_o(op64), .dest_wen_o(wen64), .ebreak_o(ebk64),
        .illegal_o(ill64)
    );

    bundle_t act32, act64;
    assign act32 = '{pc: {32'b0, pc32}, o1: {32'b0, a32}, o2: {32'b0, b32}, o3: {32'b0, c32},
                     o4: {32'b0, d32}, rs1: rs1_32, rs2: rs2_32, rd: rd32, cs: cs32, ss: ss32,
                     jf: jf32, jw: jw32, op: op32, wen: wen32, ebk: ebk32, ill: ill32};
    assign act64 = '{pc: pc64, o1: a64, o2: b64, o3: c64, o4: d64, rs1: rs1_64, rs2: rs2_64,
                     rd: rd64, cs: cs64, ss: ss64, jf: jf64, jw: jw64, op: op64, wen: wen64,
                     ebk: ebk64, ill: ill64};

    int n_tests = 0;
    int n_fail = 0;

    task automatic check(input string nm, input logic [365:0] act, input logic [365:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Instruction table: name, mask, match, xlen restriction (0 = both)
    string       t_name[$];
    logic [31:0] t_mask[$], t_match[$];
    int          t_xl[$];

    task automatic add(input string n, input logic [31:0] m, input logic [31:0] v, input int x);
        t_name.push_back(n); t_mask.push_back(m); t_match.push_back(v); t_xl.push_back(x);
    endtask

    task automatic build_table();
        add("lui", 32'h7F, 32'h37, 0);           add("auipc", 32'h7F, 32'h17, 0);
        add("jal", 32'h7F, 32'h6F, 0);           add("jalr", 32'h707F, 32'h67, 0);
        add("beq", 32'h707F, 32'h63, 0);         add("bne", 32'h707F, 32'h1063, 0);
        add("blt", 32'h707F, 32'h4063, 0);       add("bge", 32'h707F, 32'h5063, 0);
        add("bltu", 32'h707F, 32'h6063, 0);      add("bgeu", 32'h707F, 32'h7063, 0);
        add("lb", 32'h707F, 32'h03, 0);          add("lh", 32'h707F, 32'h1003, 0);
        add("lw", 32'h707F, 32'h2003, 0);        add("ld", 32'h707F, 32'h3003, 64);
        add("lbu", 32'h707F, 32'h4003, 0);       add("lhu", 32'h707F, 32'h5003, 0);
        add("lwu", 32'h707F, 32'h6003, 64);      add("sb", 32'h707F, 32'h23, 0);
        add("sh", 32'h707F, 32'h1023, 0);        add("sw", 32'h707F, 32'h2023, 0);
        add("sd", 32'h707F, 32'h3023, 64);       add("addi", 32'h707F, 32'h13, 0);
        add("slti", 32'h707F, 32'h2013, 0);      add("sltiu", 32'h707F, 32'h3013, 0);
        add("xori", 32'h707F, 32'h4013, 0);      add("ori", 32'h707F, 32'h6013, 0);
        add("andi", 32'h707F, 32'h7013, 0);
        add("slli", 32'hFE00707F, 32'h1013, 32); add("slli", 32'hFC00707F, 32'h1013, 64);
        add("srli", 32'hFE00707F, 32'h5013, 32); add("srli", 32'hFC00707F, 32'h5013, 64);
        add("srai", 32'hFE00707F, 32'h40005013, 32);
        add("srai", 32'hFC00707F, 32'h40005013, 64);
        add("add", 32'hFE00707F, 32'h33, 0);     add("sub", 32'hFE00707F, 32'h40000033, 0);
        add("sll", 32'hFE00707F, 32'h1033, 0);   add("slt", 32'hFE00707F, 32'h2033, 0);
        add("sltu", 32'hFE00707F, 32'h3033, 0);  add("xor", 32'hFE00707F, 32'h4033, 0);
        add("srl", 32'hFE00707F, 32'h5033, 0);   add("sra", 32'hFE00707F, 32'h40005033, 0);
        add("or", 32'hFE00707F, 32'h6033, 0);    add("and", 32'hFE00707F, 32'h7033, 0);
        add("addiw", 32'h707F, 32'h1B, 64);      add("slliw", 32'hFE00707F, 32'h101B, 64);
        add("srliw", 32'hFE00707F, 32'h501B, 64);
        add("sraiw", 32'hFE00707F, 32'h4000501B, 64);
        add("addw", 32'hFE00707F, 32'h3B, 64);   add("subw", 32'hFE00707F, 32'h4000003B, 64);
        add("sllw", 32'hFE00707F, 32'h103B, 64); add("srlw", 32'hFE00707F, 32'h503B, 64);
        add("sraw", 32'hFE00707F, 32'h4000503B, 64);
        add("ebreak", 32'hFFFFFFFF, Ebreak, 0);
    endtask

    function automatic string lookup(input logic [31:0] w, input bit rv64);
        for (int i = 0; i < t_name.size(); i++) begin
            if (((w & t_mask[i]) == t_match[i]) && (t_xl[i] == 0 || t_xl[i] == (rv64 ? 64 : 32)))
                return t_name[i];
        end
        return "";
    endfunction

    function automatic bit has(input string lst, input string n);
        string k;
        k = {" ", n, " "};
        for (int i = 0; i + k.len() <= lst.len(); i++) begin
            if (lst.substr(i, i + k.len() - 1) == k) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic bundle_t model(input logic [31:0] w, input logic [63:0] p,
                                      input logic [63:0] s1, input logic [63:0] s2,
                                      input bit rv64);
        bundle_t     b;
        logic [63:0] msk, imm;
        logic [6:0]  opc;
        string       nm;
        bit          brn, sto, ebk;
        b   = '0;
        msk = rv64 ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
        opc = w[6:0];
        case (opc)
            7'h37, 7'h17: imm = {{32{w[31]}}, w[31:12], 12'b0};
            7'h6F:        imm = {{44{w[31]}}, w[19:12], w[20], w[30:21], 1'b0};
            7'h23:        imm = {{52{w[31]}}, w[31:25], w[11:7]};
            7'h63:        imm = {{52{w[31]}}, w[7], w[30:25], w[11:8], 1'b0};
            7'h67, 7'h03, 7'h13, 7'h1B, 7'h73: imm = {{52{w[31]}}, w[31:20]};
            default:      imm = '0;
        endcase
        imm  = imm & msk;
        b.pc = p & msk;
        b.o1 = ((opc == 7'h17) ? p : (opc inside {7'h6F, 7'h67, 7'h37}) ? 64'd0 : s1) & msk;
        b.o2 = ((opc inside {7'h6F, 7'h67}) ? p + 64'd4 :
                (opc inside {7'h63, 7'h33, 7'h3B}) ? s2 : imm) & msk;
        b.o3 = ((opc == 7'h67) ? s1 : p) & msk;
        b.o4 = imm;
        b.rs1 = w[19:15];
        b.rs2 = w[24:20];
        b.rd  = w[11:7];
        ebk   = (w == Ebreak);
        b.ebk = ebk;
        nm    = lookup(w, rv64);
        b.ill = (nm == "");
        if (!b.ill) begin
            brn  = has(" beq bne blt bge bltu bgeu ", nm);
            sto  = has(" sb sh sw sd ", nm);
            b.cs = {nm == "ld",
                    has(" addiw slliw srliw sraiw addw subw sllw srlw sraw ", nm),
                    has(" lw lwu ", nm), has(" lh lhu ", nm), has(" lb lbu ", nm),
                    has(" lb lh lw ld lbu lhu lwu ", nm),
                    nm == "bgeu", nm == "bge", nm == "bne", nm == "beq", nm == "bltu",
                    nm == "blt",
                    has(" slt sltu slti sltiu ", nm),
                    has(" sltu sltiu lbu lhu lwu ", nm),
                    has(" sll srl sra slli srli srai sllw srlw sraw slliw srliw sraiw ", nm),
                    w[30],
                    has(" sll slli sllw slliw ", nm),
                    has(" and andi ", nm), has(" xor xori ", nm), has(" or ori ", nm)};
            b.ss  = {nm == "sd", nm == "sw", nm == "sh", nm == "sb", sto};
            b.jf  = brn;
            b.jw  = has(" jal jalr ", nm);
            b.op  = brn | has(" slt sltu slti sltiu sub subw ", nm);
            b.wen = !(brn | sto | ebk);
        end
        return b;
    endfunction

    // Transaction model: one held bundle per width, a valid flag and a halt flag
    bit      m_valid, m_halt;
    bundle_t m_b32, m_b64;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid = 1'b0;
            m_halt  = 1'b0;
        end else begin
            bit acc;
            acc = in_valid && !m_halt && !flush && (!m_valid || out_ready);
            if (flush) begin
                m_valid = 1'b0;
            end else if (acc) begin
                m_valid = 1'b1;
                m_b32   = model(inst, pc, src1, src2, 1'b0);
                m_b64   = model(inst, pc, src1, src2, 1'b1);
                if (inst == Ebreak) m_halt = 1'b1;
            end else if (out_ready) begin
                m_valid = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            bit er;
            er = !m_halt && !flush && (!m_valid || out_ready);
            check("in_ready32", rdy32, er);
            check("in_ready64", rdy64, er);
            check("out_valid32", vld32, m_valid);
            check("out_valid64", vld64, m_valid);
            if (m_valid) begin
                check("bundle32", act32, m_b32);
                check("bundle64", act64, m_b64);
            end
        end
    end

    task automatic drive(input bit v, input logic [31:0] w, input logic [63:0] p,
                         input logic [63:0] a, input logic [63:0] b, input bit fl, input bit r);
        in_valid = v; inst = w; pc = p; src1 = a; src2 = b; flush = fl; out_ready = r;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] gen_inst();
        logic [31:0] w;
        int k, i, bitpos;
        k = $urandom_range(0, 99);
        if (k < 12) begin
            w = $urandom;
        end else begin
            i = $urandom_range(0, t_name.size() - 2);
            w = ($urandom & ~t_mask[i]) | t_match[i];
            if (k >= 88) begin
                bitpos = $urandom_range(0, 31);
                w[bitpos] = ~w[bitpos];
            end
        end
        if (w == Ebreak) w = 32'h0000_0013;
        return w;
    endfunction

    localparam logic [31:0] InstA = 32'h0070_0193;  // addi x3,x0,7
    localparam logic [31:0] InstB = 32'h0090_0213;  // addi x4,x0,9

    initial begin
        build_table();
        drive(0, 0, 0, 0, 0, 0, 1);
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid32", vld32, 1'b0);
        check("rst_in_ready32", rdy32, 1'b1);
        check("rst_bundle32", act32, '0);
        check("rst_bundle64", act64, '0);
        rst_n = 1'b1;
        step();

        // addi x1,x0,5
        drive(1, 32'h0050_0093, 64'h8000_0000, 0, 0, 0, 1);
        step();
        drive(0, 0, 0, 0, 0, 0, 1);
        check("addi_valid", vld32, 1'b1);
        check("addi_rd", rd32, 5'd1);
        check("addi_op1", a32, 32'd0);
        check("addi_op2", b32, 32'd5);
        check("addi_wen", wen32, 1'b1);
        check("addi_ill", ill32, 1'b0);
        step();
        check("addi_drain", vld32, 1'b0);

        // jal x1,8
        drive(1, 32'h0080_00EF, 64'h8000_0010, 64'h1234, 0, 0, 1);
        step();
        drive(0, 0, 0, 0, 0, 0, 1);
        check("jal_op1", a32, 32'd0);
        check("jal_op2", b32, 32'h8000_0014);
        check("jal_op3", c32, 32'h8000_0010);
        check("jal_op4", d32, 32'd8);
        check("jal_jw", jw32, 1'b1);
        check("jal_wen", wen32, 1'b1);
        check("jal_op2_64", b64, 64'h0000_0000_8000_0014);
        step();

        // Backpressure: first accepted, second waits, both visible in order
        drive(1, InstA, 64'h100, 0, 0, 0, 0);
        step();
        drive(1, InstB, 64'h104, 0, 0, 0, 0);
        #1;
        check("bp_ready_low", rdy32, 1'b0);
        step();
        check("bp_frozen_rd", rd32, 5'd3);
        check("bp_frozen_op2", b32, 32'd7);
        out_ready = 1'b1;
        #1;
        check("bp_ready_high", rdy32, 1'b1);
        step();
        drive(0, 0, 0, 0, 0, 0, 1);
        check("bp_second_rd", rd32, 5'd4);
        check("bp_second_valid", vld32, 1'b1);
        step();

        // Flush with a held bundle and an incoming instruction
        drive(1, InstA, 64'h200, 0, 0, 0, 0);
        step();
        drive(1, InstB, 64'h204, 0, 0, 1, 0);
        #1;
        check("flush_ready", rdy32, 1'b0);
        step();
        check("flush_valid", vld32, 1'b0);
        drive(0, 0, 0, 0, 0, 0, 1);
        step();
        check("flush_no_accept", vld32, 1'b0);
        drive(1, InstB, 64'h204, 0, 0, 0, 1);
        step();
        drive(0, 0, 0, 0, 0, 0, 1);
        check("flush_reaccept", rd32, 5'd4);
        step();

        // slli x1,x1,32 and addw x1,x1,x2
        drive(1, 32'h0200_9093, 64'h300, 64'h55, 64'h66, 0, 1);
        step();
        drive(0, 0, 0, 0, 0, 0, 1);
        check("slli32_ill", ill32, 1'b1);
        check("slli32_wen", wen32, 1'b0);
        check("slli64_ill", ill64, 1'b0);
        check("slli64_op2", b64, 64'd32);
        check("slli64_lr", cs64[3], 1'b1);
        check("slli64_shift", cs64[5], 1'b1);
        drive(1, 32'h0020_80BB, 64'h304, 64'h55, 64'h66, 0, 1);
        step();
        drive(0, 0, 0, 0, 0, 0, 1);
        check("addw32_ill", ill32, 1'b1);
        check("addw32_wen", wen32, 1'b0);
        check("addw64_ill", ill64, 1'b0);
        check("addw64_w", cs64[18], 1'b1);
        check("addw64_op", op64, 1'b0);
        step();

        // ebreak halts intake until reset
        drive(1, Ebreak, 64'h400, 0, 0, 0, 1);
        step();
        drive(1, InstA, 64'h404, 0, 0, 0, 1);
        check("ebreak_flag", ebk32, 1'b1);
        check("ebreak_wen", wen32, 1'b0);
        for (int i = 0; i < 22; i++) begin
            step();
            check("halt_ready", rdy32, 1'b0);
        end
        rst_n = 1'b0;
        #1;
        check("rst_release_ready", rdy32, 1'b1);
        check("rst_release_valid", vld32, 1'b0);
        step();
        rst_n = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 1);
        step();

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            inst      = gen_inst();
            pc        = {$urandom, $urandom} & ~64'h3;
            if ($urandom_range(0, 15) == 0) pc = 64'hFFFF_FFFF_FFFF_FFFC;
            src1      = {$urandom, $urandom};
            src2      = {$urandom, $urandom};
            flush     = ($urandom_range(0, 9) == 0);
            out_ready = ($urandom_range(0, 9) < 7);
            step();
        end
        drive(0, 0, 0, 0, 0, 0, 1);
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
